// File: rtl/mem_responder_if.sv
// CPU memory bus and console drain signals of the memory responder.
// The master side is the CPU/board; the slave side is the responder.
interface mem_responder_if #(
    parameter int ADDR_W = 18
) ();
    logic [ADDR_W-1:0] read0_addr;
    logic [31:0]       read0_data;
    logic              re;
    logic [ADDR_W-1:0] read1_addr;
    logic [31:0]       read1_data;
    logic [3:0]        we;
    logic [31:0]       write_data;
    logic              con_valid;
    logic [7:0]        con_data;
    logic              con_ready;
    logic              irq_con;

    modport master (
        output read0_addr, re, read1_addr, we, write_data, con_ready,
        input  read0_data, read1_data, con_valid, con_data, irq_con
    );

    modport slave (
        input  read0_addr, re, read1_addr, we, write_data, con_ready,
        output read0_data, read1_data, con_valid, con_data, irq_con
    );
endinterface

// File: rtl/mem_responder.sv
// Word RAM with write-first read ports, plus an MMIO window holding
// a console transmit FIFO, its status/overflow flag and an IRQ enable.
module mem_responder #(
    parameter int                ADDR_W     = 18,
    parameter int                RAM_WORDS  = 16384,
    parameter logic [ADDR_W-1:0] MMIO_BASE  = 18'h3FFF0,
    parameter int                FIFO_DEPTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clk_en,
    mem_responder_if.slave bus
);
    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] RAM_TOP = ADDR_W'(RAM_WORDS);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);

    logic [31:0]      r_mem [RAM_WORDS];
    logic [31:0]      r_read0_data;
    logic [31:0]      r_read1_data;
    logic [7:0]       r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_overflow;
    logic             r_irq_en;
    logic             r_irq_con;

    logic              w_r0_ram;
    logic              w_r1_ram;
    logic [ADDR_W-1:0] w_r1_off;
    logic              w_r1_mmio;
    logic [3:0]        w_r1_reg;
    logic              w_wr_ram;
    logic [31:0]       w_old_word;
    logic [31:0]       w_merged;
    logic [31:0]       w_r0_word;
    logic [31:0]       w_r1_word;
    logic [31:0]       w_status;
    logic              w_full;
    logic              w_empty;
    logic              w_push_req;
    logic              w_push;
    logic              w_pop;
    logic              w_ovf_set;
    logic              w_ovf_clr;
    logic              w_irq_wr;

    assign w_r0_ram  = bus.read0_addr < RAM_TOP;
    assign w_r1_ram  = bus.read1_addr < RAM_TOP;
    assign w_r1_off  = bus.read1_addr - MMIO_BASE;
    assign w_r1_mmio = (bus.read1_addr >= MMIO_BASE)
                     && (w_r1_off < ADDR_W'(16));
    assign w_r1_reg  = w_r1_off[3:0];
    assign w_wr_ram  = clk_en && (|bus.we) && w_r1_ram;
    assign w_old_word = r_mem[bus.read1_addr[RAM_AW-1:0]];

    assign w_full  = r_count == CNT_FULL;
    assign w_empty = r_count == '0;
    assign w_pop   = !w_empty && bus.con_ready;

    assign w_push_req = clk_en && bus.we[0] && w_r1_mmio
                      && (w_r1_reg == 4'd0);
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_ovf_set  = w_push_req && w_full && !w_pop;
    assign w_ovf_clr  = clk_en && bus.we[1] && w_r1_mmio
                      && (w_r1_reg == 4'd1) && bus.write_data[8];
    assign w_irq_wr   = clk_en && bus.we[0] && w_r1_mmio
                      && (w_r1_reg == 4'd2);

    // Byte-merge store data into the currently addressed word.
    always_comb begin
        w_merged = w_old_word;
        for (int i = 0; i < 4; i++) begin
            if (bus.we[i]) w_merged[8*i +: 8] = bus.write_data[8*i +: 8];
        end
    end

    // Status word: bit0 full, bit1 empty, [5:2] count, bit8 overflow.
    always_comb begin
        w_status      = '0;
        w_status[0]   = w_full;
        w_status[1]   = w_empty;
        w_status[5:2] = 4'(r_count);
        w_status[8]   = r_overflow;
    end

    // Port 0: RAM only, sees a same-edge store to the same word.
    always_comb begin
        w_r0_word = '0;
        if (w_r0_ram) begin
            if (w_wr_ram && (bus.read0_addr == bus.read1_addr))
                w_r0_word = w_merged;
            else
                w_r0_word = r_mem[bus.read0_addr[RAM_AW-1:0]];
        end
    end

    // Port 1: RAM (write-first) or MMIO register decode.
    always_comb begin
        w_r1_word = '0;
        unique case (1'b1)
            w_r1_ram:  w_r1_word = w_wr_ram ? w_merged : w_old_word;
            w_r1_mmio: begin
                if (w_r1_reg == 4'd1)
                    w_r1_word = w_status;
                else if (w_r1_reg == 4'd2)
                    w_r1_word = {31'b0, r_irq_en};
            end
            default:   w_r1_word = '0;
        endcase
    end

    // RAM array and FIFO storage carry no reset.
    always_ff @(posedge clk) begin
        if (w_wr_ram) r_mem[bus.read1_addr[RAM_AW-1:0]] <= w_merged;
        if (w_push)   r_fifo[r_wr_ptr] <= bus.write_data[7:0];
    end

    // Read data registers advance on enabled edges only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_read0_data <= '0;
            r_read1_data <= '0;
        end else if (clk_en) begin
            r_read0_data <= w_r0_word;
            if (bus.re) r_read1_data <= w_r1_word;
        end
    end

    // FIFO pointers/count: push is enable-gated, pop runs every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    // Control flags: sticky overflow, IRQ enable, registered IRQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_irq_en   <= 1'b0;
            r_irq_con  <= 1'b0;
        end else begin
            if (w_ovf_set)      r_overflow <= 1'b1;
            else if (w_ovf_clr) r_overflow <= 1'b0;
            if (w_irq_wr) r_irq_en <= bus.write_data[0];
            r_irq_con <= r_irq_en && w_empty;
        end
    end

    assign bus.read0_data = r_read0_data;
    assign bus.read1_data = r_read1_data;
    assign bus.con_valid  = !w_empty;
    assign bus.con_data   = w_empty ? 8'h00 : r_fifo[r_rd_ptr];
    assign bus.irq_con    = r_irq_con;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a vector table for RAM/MMIO reads
// and writes, then hand sequences for the FIFO, IRQ and reset cases.
module tb_mem_responder;
    localparam logic [17:0] MB = 18'h3FFF0;

    logic clk;
    logic rst_n;
    logic clk_en;
    int   checks;
    int   errors;

    mem_responder_if #(.ADDR_W(18)) bus ();

    mem_responder dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .bus    (bus.slave)
    );

    typedef struct {
        logic        en;
        logic        re;
        logic [17:0] a0;
        logic [17:0] a1;
        logic [3:0]  we;
        logic [31:0] wd;
        logic        c0;
        logic [31:0] e0;
        logic        c1;
        logic [31:0] e1;
    } vec_t;

    vec_t vecs [15];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic en, input logic re,
                          input logic [17:0] a0, input logic [17:0] a1,
                          input logic [3:0] we, input logic [31:0] wd);
        clk_en         = en;
        bus.re         = re;
        bus.read0_addr = a0;
        bus.read1_addr = a1;
        bus.we         = we;
        bus.write_data = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, '0, '0, 4'h0, '0);
    endtask

    task automatic push(input logic [7:0] b);
        set_in(1'b1, 1'b0, '0, MB, 4'h1, {24'h0, b});
        step();
    endtask

    task automatic rd_status(input logic [31:0] exp, input string nm);
        set_in(1'b1, 1'b1, '0, MB + 18'd1, 4'h0, '0);
        step();
        check(nm, bus.read1_data, exp);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.con_ready = 1'b0;
        idle();

        vecs[0]  = '{1, 0, 0, 5, 4'hF, 32'h55555555, 0, 0, 0, 0};
        vecs[1]  = '{1, 0, 0, 0, 4'hF, 32'h0BADF00D, 0, 0, 0, 0};
        vecs[2]  = '{1, 1, 5, 5, 4'h0, 0,
                     1, 32'h55555555, 1, 32'h55555555};
        vecs[3]  = '{1, 1, 0, 10, 4'hF, 32'hDEADBEEF,
                     1, 32'h0BADF00D, 1, 32'hDEADBEEF};
        vecs[4]  = '{1, 0, 0, 10, 4'h1, 32'h000000AA,
                     1, 32'h0BADF00D, 1, 32'hDEADBEEF};
        vecs[5]  = '{1, 1, 10, 10, 4'h0, 0,
                     1, 32'hDEADBEAA, 1, 32'hDEADBEAA};
        vecs[6]  = '{0, 1, 0, 10, 4'hF, 0,
                     1, 32'hDEADBEAA, 1, 32'hDEADBEAA};
        vecs[7]  = '{1, 1, 10, 10, 4'h0, 0,
                     1, 32'hDEADBEAA, 1, 32'hDEADBEAA};
        vecs[8]  = '{1, 0, 20, 20, 4'hF, 32'h12345678,
                     1, 32'h12345678, 1, 32'hDEADBEAA};
        vecs[9]  = '{1, 1, 20, 20, 4'h6, 32'hAABBCCDD,
                     1, 32'h12BBCC78, 1, 32'h12BBCC78};
        vecs[10] = '{1, 1, 18'h4000, 18'h4000, 4'hF, 32'hFFFFFFFF,
                     1, 0, 1, 0};
        vecs[11] = '{1, 1, 0, 0, 4'h0, 0,
                     1, 32'h0BADF00D, 1, 32'h0BADF00D};
        vecs[12] = '{1, 1, 18'h3FFF1, MB + 18'd1, 4'h0, 0,
                     1, 0, 1, 32'h2};
        vecs[13] = '{1, 1, 0, MB + 18'd3, 4'hF, 32'hFFFFFFFF,
                     1, 32'h0BADF00D, 1, 0};
        vecs[14] = '{1, 1, 10, MB, 4'h0, 0,
                     1, 32'hDEADBEAA, 1, 0};

        repeat (2) @(posedge clk);
        #1;
        check("rst_r0", bus.read0_data, 0);
        check("rst_r1", bus.read1_data, 0);
        check("rst_cv", {31'b0, bus.con_valid}, 0);
        check("rst_cd", {24'b0, bus.con_data}, 0);
        check("rst_irq", {31'b0, bus.irq_con}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 15; i++) begin
            set_in(vecs[i].en, vecs[i].re, vecs[i].a0, vecs[i].a1,
                   vecs[i].we, vecs[i].wd);
            step();
            if (vecs[i].c0)
                check($sformatf("vec%0d_r0", i), bus.read0_data, vecs[i].e0);
            if (vecs[i].c1)
                check($sformatf("vec%0d_r1", i), bus.read1_data, vecs[i].e1);
        end
        check("vec_no_push", {31'b0, bus.con_valid}, 0);

        // Fill past full: byte 9 dropped, overflow set.
        for (int b = 1; b <= 9; b++) push(8'(b));
        rd_status(32'h121, "stat_full_ovf");
        check("head_1", {24'b0, bus.con_data}, 32'h1);
        idle();
        bus.con_ready = 1'b1;
        for (int b = 1; b <= 8; b++) begin
            check($sformatf("drain_v%0d", b), {31'b0, bus.con_valid}, 1);
            check($sformatf("drain_d%0d", b), {24'b0, bus.con_data}, b);
            step();
        end
        check("drain_empty", {31'b0, bus.con_valid}, 0);
        rd_status(32'h102, "stat_empty_ovf");
        set_in(1'b1, 1'b0, '0, MB + 18'd1, 4'h2, 32'h100);
        step();
        rd_status(32'h2, "stat_ovf_clr");

        // Push with clk_en low is ignored.
        bus.con_ready = 1'b0;
        set_in(1'b0, 1'b0, '0, MB, 4'h1, 32'h77);
        step();
        step();
        check("gated_push", {31'b0, bus.con_valid}, 0);

        // Full FIFO, push and pop on one edge.
        for (int b = 10; b <= 17; b++) push(8'(b));
        bus.con_ready = 1'b1;
        push(8'd18);
        bus.con_ready = 1'b0;
        rd_status(32'h21, "stat_full_pp");
        check("head_11", {24'b0, bus.con_data}, 32'd11);
        idle();
        bus.con_ready = 1'b1;
        for (int b = 11; b <= 18; b++) begin
            check($sformatf("pp_d%0d", b), {24'b0, bus.con_data}, b);
            step();
        end
        check("pp_empty", {31'b0, bus.con_valid}, 0);

        // Push and pop while empty: byte kept.
        push(8'h33);
        check("ep_valid", {31'b0, bus.con_valid}, 1);
        check("ep_data", {24'b0, bus.con_data}, 32'h33);
        idle();
        step();
        check("ep_gone", {31'b0, bus.con_valid}, 0);
        bus.con_ready = 1'b0;

        // Interrupt timing.
        set_in(1'b1, 1'b0, '0, MB + 18'd2, 4'h1, 32'h1);
        step();
        check("irq_lag", {31'b0, bus.irq_con}, 0);
        set_in(1'b1, 1'b1, '0, MB + 18'd2, 4'h0, '0);
        step();
        check("irq_en_rd", bus.read1_data, 1);
        check("irq_on", {31'b0, bus.irq_con}, 1);
        push(8'h44);
        check("irq_push_lag", {31'b0, bus.irq_con}, 1);
        idle();
        step();
        check("irq_off", {31'b0, bus.irq_con}, 0);
        bus.con_ready = 1'b1;
        step();
        check("irq_drain_lag", {31'b0, bus.irq_con}, 0);
        check("irq_drain_cv", {31'b0, bus.con_valid}, 0);
        step();
        check("irq_back", {31'b0, bus.irq_con}, 1);

        // Reset in the middle of a drain.
        bus.con_ready = 1'b0;
        push(8'h51);
        push(8'h52);
        push(8'h53);
        idle();
        step();
        check("mid_irq0", {31'b0, bus.irq_con}, 0);
        bus.con_ready = 1'b1;
        step();
        check("mid_head", {24'b0, bus.con_data}, 32'h52);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_cv", {31'b0, bus.con_valid}, 0);
        check("arst_cd", {24'b0, bus.con_data}, 0);
        check("arst_irq", {31'b0, bus.irq_con}, 0);
        check("arst_r1", bus.read1_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.con_ready = 1'b0;
        step();
        step();
        check("post_irq", {31'b0, bus.irq_con}, 0);
        rd_status(32'h2, "post_stat");
        set_in(1'b1, 1'b1, '0, MB + 18'd2, 4'h0, '0);
        step();
        check("post_irq_en", bus.read1_data, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
